l1_bus_ctrl: RTL
================

Name: l1_bus_ctrl

Overview:
- Cache bus unit directly downstream of the per-port BIU cell's L1.
- Services the L1's three request types against the system bus through a simple req/ack master port:
  - single uncached read
  - write-through store
  - cache-line refill
- Returns refill beats, completion and error pulses back to the L1.
- One instance per BIU cell; the arbiter between instances sits outside this block.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of two, 16..2048.
- BEAT_BYTES, 8, bus data width in bytes; fixed at 8 (64-bit bus).
- TIMEOUT_CYC, 255, cycles without bus_ack (or bus_err) before a transfer is declared a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- L1_write_through_req  in  1  level request; write wt_data to pa.
- read_req  in  1  level request; single uncached read of pa.
- read_line_req  in  1  level request; refill the line containing pa.
- L1_size  in  4  one-hot access size (0001=1B, 0010=2B, 0100=4B, 1000=8B).
- pa  in  64  physical address.
- wt_data  in  64  write data.
- line_data  out  64  refill beat data, or single-read data.
- addr_count  out  11  byte offset within the line of the beat on line_data.
- line_write  out  1  one-cycle pulse: line_data/addr_count valid for a refill beat.
- cache_entry_write  out  1  one-cycle pulse: refill complete, L1 updates tag/valid.
- trans_rdy  out  1  one-cycle pulse: request completed successfully.
- bus_error  out  1  one-cycle pulse: request aborted.
- bus_req  out  1  bus request; held until bus_ack or bus_err.
- bus_we  out  1  1 = write.
- bus_addr  out  64  bus address.
- bus_size  out  4  one-hot size.
- bus_wdata  out  64  write data.
- bus_ack  in  1  beat accepted/complete; bus_rdata valid the same cycle.
- bus_rdata  in  64  read data.
- bus_err  in  1  bus-side error response (instead of ack).

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including line_data, addr_count and bus_addr. Reset mid-transfer abandons it with no pulse; the bus side must tolerate a dropped bus_req.
- All outputs are registered.
- States: IDLE, RD, WR, LINE, FILL_DONE, DONE, ERR.
- IDLE:
  - Samples requests with priority write_through > read_line > read.
  - WR: bus_req=1, bus_we=1, bus_addr=pa, bus_size=L1_size, bus_wdata=wt_data.
  - RD: bus_req=1, bus_we=0, bus_addr=pa, bus_size=L1_size.
  - LINE: bus_req=1, bus_we=0, bus_size=1000, bus_addr=pa with the low log2(LINE_BYTES) bits cleared; beat counter=0.
  - Request fields are captured at entry. pa, L1_size and wt_data are ignored afterwards.
- bus_req rises the cycle after the request is sampled.
- bus_req is held with stable addr/size/we/wdata until bus_ack or bus_err; it drops the cycle after.
- RD/WR:
  - On bus_ack → DONE; RD also loads line_data<=bus_rdata.
  - DONE drives trans_rdy=1 for one cycle, then → IDLE.
- LINE:
  - Each bus_ack registers line_data<=bus_rdata, addr_count<=beat*8 and pulses line_write the next cycle.
  - bus_addr advances by 8. bus_req is deasserted one cycle between beats.
  - Beats total LINE_BYTES/8.
  - After the last beat's line_write → FILL_DONE. FILL_DONE asserts cache_entry_write and trans_rdy together for one cycle, then → IDLE.
- Errors:
  - bus_err, or TIMEOUT_CYC cycles with bus_req high and no ack, in any active state → ERR.
  - ERR pulses bus_error for one cycle, then → IDLE.
  - A line refill that errors never pulses cache_entry_write; already-written beats are left to the L1 to discard.
  - bus_ack and bus_err in the same cycle: bus_err wins.
- Handshake with the L1:
  - Requests stay asserted until trans_rdy/bus_error.
  - The L1 deasserts at the edge on which it sees the pulse.
  - IDLE resamples only in the cycle after DONE/FILL_DONE/ERR, so a completed request is never re-issued.
- Timeout counter: 8+ bits (sized to TIMEOUT_CYC); reset on every ack and on entry to an active state.
- Byte-lane alignment of wt_data/bus_rdata is the bus's concern; data passes unmodified.

Decomposition:
- Shared package (biu_pkg):
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state enum
  - BEAT_BYTES constant
  - line offset width function
- Natural sub-module: l1_bus_timeout (loadable down-counter with expire flag), reused by the TLB bus unit.

Test Plan:
- Reset during a LINE refill at beat 3 → all outputs 0 immediately; after release, IDLE; no trans_rdy/bus_error emitted.
- read_req, pa=0x8000_0010, size=0100, ack after 2 cycles with rdata=0x1122334455667788 → bus_addr=0x8000_0010, bus_size=0100; then line_data=0x1122334455667788 and one trans_rdy pulse.
- read_line_req, pa=0x8000_0128, LINE_BYTES=64, immediate acks → bus_addr 0x8000_0100..0x8000_0138 step 8; 8 line_write pulses with addr_count 0,8,…,56; then one cycle with cache_entry_write=trans_rdy=1.
- Write-through and read_line asserted together → write issued first (bus_we=1, bus_wdata=wt_data); trans_rdy; then the refill proceeds.
- Refill with bus_err on beat 5 → 5 line_write pulses, one bus_error, no cache_entry_write, state IDLE.
- TIMEOUT_CYC=4, read with no ack → bus_error exactly 4 cycles after bus_req rises; bus_req then drops.

Source files
------------

// File: rtl/l1_bus_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | biu_pkg: shared BIU bus-unit types and helpers.  Rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

package biu_pkg;

  localparam int BEAT_BYTES = 8;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_WR        = 3'd2,
    ST_LINE      = 3'd3,
    ST_FILL_DONE = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } bus_state_e;

  function automatic int line_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_bus_ctrl_if.sv
// +------------------------------------------------------------------+
// | l1_bus_ctrl_if: L1 request side and system-bus master port.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface l1_bus_ctrl_if;
  logic        L1_write_through_req;
  logic        read_req;
  logic        read_line_req;
  logic [3:0]  L1_size;
  logic [63:0] pa;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write;
  logic        cache_entry_write;
  logic        trans_rdy;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [3:0]  bus_size;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        bus_err;

  modport master (
    input  L1_write_through_req, read_req, read_line_req, L1_size, pa, wt_data,
    input  bus_ack, bus_rdata, bus_err,
    output line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error,
    output bus_req, bus_we, bus_addr, bus_size, bus_wdata
  );

  modport slave (
    output L1_write_through_req, read_req, read_line_req, L1_size, pa, wt_data,
    output bus_ack, bus_rdata, bus_err,
    input  line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error,
    input  bus_req, bus_we, bus_addr, bus_size, bus_wdata
  );
endinterface

`default_nettype wire

// File: rtl/l1_bus_ctrl_timeout.sv
// +------------------------------------------------------------------+
// | l1_bus_timeout: loadable down-counter with expire flag. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module l1_bus_timeout #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             run_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with limit-1, so the last waiting cycle is the one that reads zero.
  assign expired_o = run_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/l1_bus_ctrl.sv
// +------------------------------------------------------------------+
// | l1_bus_ctrl: L1 uncached read / write-through / line refill      |
// | engine on a req/ack system bus.  Rev 1.0                         |
// +------------------------------------------------------------------+
`default_nettype none

module l1_bus_ctrl #(
  parameter int LINE_BYTES  = 64,
  parameter int BEAT_BYTES  = biu_pkg::BEAT_BYTES,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  l1_bus_ctrl_if.master bus_if
);
  import biu_pkg::*;

  localparam int OFF_W  = line_off_w(LINE_BYTES);
  localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_W = $clog2(NBEATS) + 1;
  localparam int TO_W   = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);

  bus_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [63:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_size_q, bus_size_d;
  logic [63:0]       bus_wdata_q, bus_wdata_d;
  logic [63:0]       line_data_q, line_data_d;
  logic [10:0]       addr_count_q, addr_count_d;
  logic              line_write_q, line_write_d;
  logic              cew_q, cew_d;
  logic              trans_rdy_q, trans_rdy_d;
  logic              bus_error_q, bus_error_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic tmr_load;
  logic tmr_expired;
  logic bus_ok;
  logic bus_fail;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      l1_bus_timeout #(.WIDTH(TO_W)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (TO_W'(TIMEOUT_CYC - 1)),
        .run_i      (bus_req_q),
        .expired_o  (tmr_expired)
      );
    end else begin : g_no_timeout
      assign tmr_expired = 1'b0;
    end
  endgenerate

  // bus_err beats a same-cycle ack; a same-cycle ack beats the timeout.
  assign bus_ok   = bus_req_q && bus_if.bus_ack && !bus_if.bus_err;
  assign bus_fail = bus_req_q && (bus_if.bus_err || (tmr_expired && !bus_if.bus_ack));

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_size_d   = bus_size_q;
    bus_wdata_d  = bus_wdata_q;
    line_data_d  = line_data_q;
    addr_count_d = addr_count_q;
    beat_d       = beat_q;
    line_write_d = 1'b0;
    cew_d        = 1'b0;
    trans_rdy_d  = 1'b0;
    bus_error_d  = 1'b0;
    tmr_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_if.L1_write_through_req) begin
          state_d     = ST_WR;
          bus_we_d    = 1'b1;
          bus_addr_d  = bus_if.pa;
          bus_size_d  = bus_if.L1_size;
          bus_wdata_d = bus_if.wt_data;
        end else if (bus_if.read_line_req) begin
          state_d    = ST_LINE;
          bus_we_d   = 1'b0;
          bus_addr_d = {bus_if.pa[63:OFF_W], {OFF_W{1'b0}}};
          bus_size_d = SZ_D;
          beat_d     = '0;
        end else if (bus_if.read_req) begin
          state_d    = ST_RD;
          bus_we_d   = 1'b0;
          bus_addr_d = bus_if.pa;
          bus_size_d = bus_if.L1_size;
        end
        if (state_d != ST_IDLE) begin
          bus_req_d = 1'b1;
          tmr_load  = 1'b1;
        end
      end

      ST_RD, ST_WR: begin
        if (bus_fail) begin
          state_d     = ST_ERR;
          bus_req_d   = 1'b0;
          bus_error_d = 1'b1;
        end else if (bus_ok) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          trans_rdy_d = 1'b1;
          if (state_q == ST_RD) begin
            line_data_d = bus_if.bus_rdata;
          end
        end
      end

      // bus_req low inside LINE is the one-cycle gap that carries line_write.
      ST_LINE: begin
        if (bus_req_q) begin
          if (bus_fail) begin
            state_d     = ST_ERR;
            bus_req_d   = 1'b0;
            bus_error_d = 1'b1;
          end else if (bus_ok) begin
            bus_req_d    = 1'b0;
            line_data_d  = bus_if.bus_rdata;
            addr_count_d = 11'(int'(beat_q) * BEAT_BYTES);
            line_write_d = 1'b1;
            bus_addr_d   = bus_addr_q + 64'(BEAT_BYTES);
            beat_d       = beat_q + BEAT_W'(1);
          end
        end else if (beat_q == BEAT_W'(NBEATS)) begin
          state_d     = ST_FILL_DONE;
          cew_d       = 1'b1;
          trans_rdy_d = 1'b1;
        end else begin
          bus_req_d = 1'b1;
          tmr_load  = 1'b1;
        end
      end

      // DONE / FILL_DONE / ERR: pulse cycle, then back without resampling.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_size_q   <= '0;
      bus_wdata_q  <= '0;
      line_data_q  <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
      cew_q        <= 1'b0;
      trans_rdy_q  <= 1'b0;
      bus_error_q  <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_size_q   <= bus_size_d;
      bus_wdata_q  <= bus_wdata_d;
      line_data_q  <= line_data_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
      cew_q        <= cew_d;
      trans_rdy_q  <= trans_rdy_d;
      bus_error_q  <= bus_error_d;
      beat_q       <= beat_d;
    end
  end

  assign bus_if.bus_req           = bus_req_q;
  assign bus_if.bus_we            = bus_we_q;
  assign bus_if.bus_addr          = bus_addr_q;
  assign bus_if.bus_size          = bus_size_q;
  assign bus_if.bus_wdata         = bus_wdata_q;
  assign bus_if.line_data         = line_data_q;
  assign bus_if.addr_count        = addr_count_q;
  assign bus_if.line_write        = line_write_q;
  assign bus_if.cache_entry_write = cew_q;
  assign bus_if.trans_rdy         = trans_rdy_q;
  assign bus_if.bus_error         = bus_error_q;

endmodule

`default_nettype wire
